// File: rtl/gol_frame_engine.sv
// gol_frame_engine
//   Frame-level Game-of-Life engine. A WIDTH x HEIGHT frame is loaded one row per
//   handshake. The engine then advances it cfg_gens generations, computing one row
//   per clock into the alternate frame buffer. The result is streamed out one row
//   per handshake. BIRTH_MASK and SURVIVE_MASK are indexed by the live-neighbour
//   count. WRAP selects between a dead border and a toroidal frame.
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cfg_gens  [GEN_W]    generation count, sampled on the first row handshake (0 => 1)
//   in_valid / in_ready  input row handshake; in_ready is high only while loading
//   in_row    [WIDTH]    input row, rows 0..HEIGHT-1, bit i = column i
//   out_valid/out_ready  output row handshake; out_valid is high only while emitting
//   out_row   [WIDTH]    result row (0 when not emitting)
//   out_last             marks row HEIGHT-1 of the result
//   busy                 high while stepping or emitting
module gol_frame_engine #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned HEIGHT       = 8,
  parameter int unsigned GEN_W        = 8,
  parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0]  SURVIVE_MASK = 9'b000001100,
  parameter bit          WRAP         = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [GEN_W-1:0] cfg_gens,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned      ROW_W    = $clog2(HEIGHT);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {S_LOAD, S_STEP, S_EMIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q [2][HEIGHT];
  logic             cur_q;
  logic [ROW_W-1:0] row_cnt_q, emit_cnt_q;
  logic [GEN_W-1:0] gens_q, gen_cnt_q;

  logic             in_hs, out_hs;
  logic [WIDTH-1:0] up_row, mid_row, dn_row, nxt_row;
  logic [WIDTH+1:0] e_up, e_mid, e_dn;
  logic [3:0]       ncnt;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (in_hs && row_cnt_q == LAST_ROW) state_d = S_STEP;
      S_STEP:  if (row_cnt_q == LAST_ROW && gen_cnt_q == GEN_W'(1)) state_d = S_EMIT;
      S_EMIT:  if (out_hs && emit_cnt_q == LAST_ROW) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_row   = '0;
    unique case (state_q)
      S_LOAD: in_ready = 1'b1;
      S_STEP: busy = 1'b1;
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_row   = buf_q[cur_q][emit_cnt_q];
        out_last  = (emit_cnt_q == LAST_ROW);
      end
      default: ;
    endcase
  end

  // Neighbourhood of row row_cnt_q in the current buffer. Each row is padded with one
  // column on each side: bit 0 is column -1 and bit WIDTH+1 is column WIDTH.
  always_comb begin
    mid_row = buf_q[cur_q][row_cnt_q];
    up_row  = '0;
    dn_row  = '0;
    if (row_cnt_q != '0) up_row = buf_q[cur_q][row_cnt_q - ROW_W'(1)];
    else if (WRAP)       up_row = buf_q[cur_q][LAST_ROW];
    if (row_cnt_q != LAST_ROW) dn_row = buf_q[cur_q][row_cnt_q + ROW_W'(1)];
    else if (WRAP)             dn_row = buf_q[cur_q][0];
    e_up  = {WRAP & up_row[0],  up_row,  WRAP & up_row[WIDTH-1]};
    e_mid = {WRAP & mid_row[0], mid_row, WRAP & mid_row[WIDTH-1]};
    e_dn  = {WRAP & dn_row[0],  dn_row,  WRAP & dn_row[WIDTH-1]};
    nxt_row = '0;
    ncnt    = '0;
    for (int unsigned c = 0; c < WIDTH; c++) begin
      ncnt = 4'(e_up[c]) + 4'(e_up[c+1]) + 4'(e_up[c+2])
           + 4'(e_mid[c])                + 4'(e_mid[c+2])
           + 4'(e_dn[c]) + 4'(e_dn[c+1]) + 4'(e_dn[c+2]);
      nxt_row[c] = e_mid[c+1] ? SURVIVE_MASK[ncnt] : BIRTH_MASK[ncnt];
    end
  end

  // Frame buffers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '{default: '0};
      cur_q      <= 1'b0;
      row_cnt_q  <= '0;
      emit_cnt_q <= '0;
      gens_q     <= '0;
      gen_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: if (in_hs) begin
          buf_q[0][row_cnt_q] <= in_row;
          if (row_cnt_q == '0) gens_q <= (cfg_gens == '0) ? GEN_W'(1) : cfg_gens;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_q <= '0;
            cur_q     <= 1'b0;
            gen_cnt_q <= gens_q;
          end else begin
            row_cnt_q <= row_cnt_q + ROW_W'(1);
          end
        end
        S_STEP: begin
          buf_q[~cur_q][row_cnt_q] <= nxt_row;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_q <= '0;
            cur_q     <= ~cur_q;
            gen_cnt_q <= gen_cnt_q - GEN_W'(1);
          end else begin
            row_cnt_q <= row_cnt_q + ROW_W'(1);
          end
        end
        S_EMIT: if (out_hs) begin
          emit_cnt_q <= (emit_cnt_q == LAST_ROW) ? '0 : emit_cnt_q + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
